// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package int_seq_pkg;

  // Address/data width of the processor.
  localparam int AW = 8;

  // Memory location that holds the ISR start address.
  localparam logic [AW-1:0] DEF_VEC_ADDR = 8'h01;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DRAIN       = 3'd1,
    SAVE        = 3'd2,
    PUSH        = 3'd3,
    VEC         = 3'd4,
    JUMP        = 3'd5,
    RET_POP     = 3'd6,
    RET_RESTORE = 3'd7
  } state_t;

endpackage

// File: rtl/int_seq_if.sv
// Memory bus between the sequencer (master) and data memory (slave).
//
// Handshake: mem_req is the valid. When mem_req=1, mem_we, mem_addr and
// mem_wdata are held stable until the cycle in which mem_ready=1; that cycle
// completes the transfer, and read data is valid in that same cycle. The
// memory may hold mem_ready low for any number of cycles. mem_ready while
// mem_req=0 carries no meaning and is ignored.
interface int_seq_if;
  import int_seq_pkg::*;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/int_seq_mem_if.sv
// Single-transfer memory port: freezes request fields while the memory waits,
// strobes done on completion and keeps the last read data.
module int_mem_if
  import int_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] wdata,
  output logic          done,
  output logic [AW-1:0] rdata,
  int_seq_if.master     mem
);

  logic          busy;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] wdata_q;
  logic [AW-1:0] rdata_q;
  logic          eff_we;

  // First cycle of a request passes straight through; later wait cycles
  // replay the captured copy so the bus cannot drift.
  assign eff_we         = busy ? we_q : we;
  assign mem.mem_req    = req;
  assign mem.mem_we     = req & eff_we;
  assign mem.mem_addr   = req ? (busy ? addr_q : addr) : '0;
  assign mem.mem_wdata  = req ? (busy ? wdata_q : wdata) : '0;
  assign done           = req & mem.mem_ready;
  assign rdata          = rdata_q;

  // Capture request fields on a stalled first cycle; release on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (!req || mem.mem_ready) begin
      busy    <= 1'b0;
    end else if (!busy) begin
      busy    <= 1'b1;
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Keep the data of the most recent completed read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (done && !eff_we) begin
      rdata_q <= mem.mem_rdata;
    end
  end

endmodule

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer: drains the pipeline, saves flags and PC,
// vectors to the ISR, and undoes it all on RTI.
module int_seq
  import int_seq_pkg::*;
#(
  parameter int            PIPE_DEPTH = 4,
  parameter logic [AW-1:0] VEC_ADDR   = DEF_VEC_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          intr_i,
  input  logic          rti_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] sp_i,
  int_seq_if.master     mem,
  output logic          stall,
  output logic          flush,
  output logic          saveF,
  output logic          returnF,
  output logic          pc_load,
  output logic [AW-1:0] pc_load_val,
  output logic          sp_dec,
  output logic          sp_inc,
  output logic          in_isr,
  output state_t        dbg_state
);

  localparam int            CW   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIPE_DEPTH - 1);

  state_t        state_q, state_d;
  logic          pending_q;
  logic          in_isr_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] saved_pc_q;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_wdata;
  logic          m_done;

  logic          drain_last;
  logic          in_ret;

  assign drain_last = (state_q == DRAIN) && (cnt_q == LAST);
  assign in_ret     = (state_q == RET_POP) || (state_q == RET_RESTORE);
  assign in_isr     = in_isr_q;
  assign dbg_state  = state_q;

  int_mem_if u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (m_req),
    .we    (m_we),
    .addr  (m_addr),
    .wdata (m_wdata),
    .done  (m_done),
    .rdata (pc_load_val),
    .mem   (mem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, strobes and memory request for the current state.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    saveF   = 1'b0;
    returnF = 1'b0;
    pc_load = 1'b0;
    sp_dec  = 1'b0;
    sp_inc  = 1'b0;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    case (state_q)
      IDLE: begin
        if (pending_q && !in_isr_q) begin
          state_d = DRAIN;
          stall   = 1'b1;
          flush   = 1'b1;
        end else if (rti_i && in_isr_q) begin
          state_d = RET_POP;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (drain_last) state_d = SAVE;
      end
      SAVE: begin
        stall   = 1'b1;
        saveF   = 1'b1;
        state_d = PUSH;
      end
      PUSH: begin
        stall   = 1'b1;
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = sp_i;
        m_wdata = saved_pc_q;
        if (m_done) begin
          sp_dec  = 1'b1;
          state_d = VEC;
        end
      end
      VEC: begin
        stall  = 1'b1;
        m_req  = 1'b1;
        m_addr = VEC_ADDR;
        if (m_done) state_d = JUMP;
      end
      JUMP: begin
        stall   = 1'b1;
        pc_load = 1'b1;
        state_d = IDLE;
      end
      RET_POP: begin
        stall  = 1'b1;
        m_req  = 1'b1;
        m_addr = sp_i + AW'(1);
        if (m_done) begin
          sp_inc  = 1'b1;
          state_d = RET_RESTORE;
        end
      end
      RET_RESTORE: begin
        stall   = 1'b1;
        returnF = 1'b1;
        pc_load = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-depth request latch; accepting it into DRAIN wins over a new set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (state_q == IDLE && state_d == DRAIN) begin
      pending_q <= 1'b0;
    end else if (intr_i && (!in_isr_q || in_ret)) begin
      pending_q <= 1'b1;
    end
  end

  // Handler-active flag: set when the ISR is entered, cleared on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      in_isr_q <= 1'b0;
    else if (state_q == JUMP)        in_isr_q <= 1'b1;
    else if (state_q == RET_RESTORE) in_isr_q <= 1'b0;
  end

  // Drain counter and resume-PC capture on the final drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      saved_pc_q <= '0;
    end else if (state_q == DRAIN) begin
      if (drain_last) begin
        cnt_q      <= '0;
        saved_pc_q <= pc_i;
      end else begin
        cnt_q      <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_int_seq.sv
// Bench for int_seq: memory model with programmable wait states, event
// monitor feeding a scoreboard of expected bus transfers and PC loads.
`timescale 1ns/1ps
module tb_int_seq;
  import int_seq_pkg::*;

  localparam logic [7:0] VEC = 8'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       intr_i = 1'b0;
  logic       rti_i  = 1'b0;
  logic [7:0] pc_i   = 8'h00;
  logic [7:0] sp_i   = 8'h00;
  logic       stall, flush, saveF, returnF, pc_load, sp_dec, sp_inc, in_isr;
  logic [7:0] pc_load_val;
  state_t     dbg_state;

  int_seq_if mem_bus ();

  int_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .intr_i      (intr_i),
    .rti_i       (rti_i),
    .pc_i        (pc_i),
    .sp_i        (sp_i),
    .mem         (mem_bus),
    .stall       (stall),
    .flush       (flush),
    .saveF       (saveF),
    .returnF     (returnF),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .sp_dec      (sp_dec),
    .sp_inc      (sp_inc),
    .in_isr      (in_isr),
    .dbg_state   (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem_arr [256];
  int         wait_cnt = 0;
  int         wr_delay = 0;
  int         rd_delay = 0;
  logic       pre_we   = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  assign mem_bus.mem_ready = mem_bus.mem_req &&
                             (wait_cnt >= (mem_bus.mem_we ? wr_delay : rd_delay));
  assign mem_bus.mem_rdata = mem_bus.mem_ready ? mem_arr[mem_bus.mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (mem_bus.mem_req && !mem_bus.mem_ready) wait_cnt <= wait_cnt + 1;
    else                                       wait_cnt <= 0;
    if (mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_ready)
      mem_arr[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    else if (pre_we)
      mem_arr[pre_addr] <= pre_data;
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_mem_q [$];   // {we, addr, wdata}
  logic [7:0]  exp_q [$];       // expected pc_load_val per pc_load

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int n_save = 0, n_ret = 0, n_dec = 0, n_inc = 0, n_load = 0, n_flush = 0;
  int n_both = 0, n_stab = 0, n_dec_bad = 0, n_wr_cyc = 0, n_unexp = 0;
  int save_cyc = 0, ret_cyc = 0, load_cyc = 0;
  logic        retf_at_load = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = 8'h00, prev_wdata = 8'h00;
  logic [16:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (saveF)   begin n_save++; save_cyc = cyc; end
      if (returnF) begin n_ret++;  ret_cyc  = cyc; end
      if (saveF && returnF) n_both++;
      if (flush) n_flush++;
      if (sp_dec) begin
        n_dec++;
        if (!(mem_bus.mem_req && mem_bus.mem_ready)) n_dec_bad++;
      end
      if (sp_inc) n_inc++;
      if (mem_bus.mem_req && mem_bus.mem_we) n_wr_cyc++;
      if (mem_bus.mem_req) begin
        if (prev_v && (mem_bus.mem_addr != prev_addr || mem_bus.mem_wdata != prev_wdata ||
                       mem_bus.mem_we != prev_we))
          n_stab++;
        prev_v     = !mem_bus.mem_ready;
        prev_we    = mem_bus.mem_we;
        prev_addr  = mem_bus.mem_addr;
        prev_wdata = mem_bus.mem_wdata;
      end else begin
        prev_v = 1'b0;
      end
      if (mem_bus.mem_req && mem_bus.mem_ready) begin
        if (exp_mem_q.size() == 0) n_unexp++;
        else begin
          mon_e = exp_mem_q.pop_front();
          if (mon_e[16])
            chk("mem_wr", {15'b0, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, {15'b0, mon_e});
          else
            chk("mem_rd", {23'b0, mem_bus.mem_we, mem_bus.mem_addr}, {23'b0, mon_e[16:8]});
        end
      end
      if (pc_load) begin
        n_load++;
        load_cyc     = cyc;
        retf_at_load = returnF;
        if (exp_q.size() == 0) n_unexp++;
        else chk("pc_load_val", {24'b0, pc_load_val}, {24'b0, exp_q.pop_front()});
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick(1);
    pre_we   = 1'b0;
  endtask

  task automatic wait_load(input string tag, input int start);
    int k;
    k = 0;
    while (n_load == start && k < 80) begin
      tick(1);
      k++;
    end
    chk(tag, n_load - start, 1);
  endtask

  task automatic do_entry(input logic [7:0] sp, input logic [7:0] pc, input logic [7:0] vec,
                          input string tag, input int exp_lat);
    int c0, l0, s0, d0, f0;
    sp_i = sp;
    pc_i = pc;
    poke(VEC, vec);
    l0 = n_load; s0 = n_save; d0 = n_dec; f0 = n_flush;
    exp_mem_q.push_back({1'b1, sp, pc});
    exp_mem_q.push_back({1'b0, VEC, 8'h00});
    exp_q.push_back(vec);
    c0 = cyc;
    intr_i = 1'b1;
    tick(1);
    intr_i = 1'b0;
    wait_load({tag, "_load"}, l0);
    chk({tag, "_lat"},    load_cyc - c0, exp_lat);
    chk({tag, "_savef"},  n_save - s0, 1);
    chk({tag, "_spdec"},  n_dec - d0, 1);
    chk({tag, "_flush"},  n_flush - f0, 1);
    chk({tag, "_pushed"}, {24'b0, mem_arr[sp]}, {24'b0, pc});
    chk({tag, "_in_isr"}, {31'b0, in_isr}, 1);
  endtask

  task automatic do_return(input logic [7:0] sp, input logic [7:0] exp_pc, input string tag);
    int c0, l0, i0, r0;
    logic [7:0] pa;
    sp_i = sp;
    pa   = sp + 8'd1;
    exp_mem_q.push_back({1'b0, pa, 8'h00});
    exp_q.push_back(exp_pc);
    l0 = n_load; i0 = n_inc; r0 = n_ret;
    c0 = cyc;
    rti_i = 1'b1;
    tick(1);
    rti_i = 1'b0;
    wait_load({tag, "_load"}, l0);
    chk({tag, "_lat"},    load_cyc - c0, 2 + rd_delay);
    chk({tag, "_retf"},   {31'b0, retf_at_load}, 1);
    chk({tag, "_nretf"},  n_ret - r0, 1);
    chk({tag, "_spinc"},  n_inc - i0, 1);
    chk({tag, "_in_isr"}, {31'b0, in_isr}, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {22'b0, stall, flush, saveF, returnF, pc_load, sp_dec, sp_inc, in_isr,
                        mem_bus.mem_req, mem_bus.mem_we}, 0);
    chk({tag, "_data"}, {8'b0, mem_bus.mem_addr, mem_bus.mem_wdata, pc_load_val}, 0);
    chk({tag, "_state"}, {29'b0, dbg_state}, {29'b0, IDLE});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, l0, w0, k;

    rst_n = 1'b0;
    tick(3);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Basic entry then return from it.
    do_entry(8'hFF, 8'h23, 8'h80, "basic", 9);
    do_return(8'hFE, 8'h23, "ret");

    // Three wait states on the push write.
    wr_delay = 3;
    w0 = n_wr_cyc;
    do_entry(8'h40, 8'h55, 8'h90, "wait", 12);
    chk("wait_wr_cycles", n_wr_cyc - w0, 4);
    wr_delay = 0;
    do_return(8'h3F, 8'h55, "wait_rti");

    // Interrupt while in the handler is masked.
    do_entry(8'h20, 8'h11, 8'hA0, "mask", 9);
    s0 = n_save;
    intr_i = 1'b1;
    tick(1);
    intr_i = 1'b0;
    tick(20);
    chk("mask_no_savef", n_save - s0, 0);

    // Interrupt arriving during RET_POP is serviced after the return.
    rd_delay = 2;
    sp_i = 8'h1F;
    pc_i = 8'h66;
    exp_mem_q.push_back({1'b0, 8'h20, 8'h00});
    exp_q.push_back(8'h11);
    exp_mem_q.push_back({1'b1, 8'h1F, 8'h66});
    exp_mem_q.push_back({1'b0, VEC, 8'h00});
    exp_q.push_back(8'hA0);
    l0 = n_load;
    s0 = n_save;
    rti_i = 1'b1;
    tick(1);
    rti_i = 1'b0;
    intr_i = 1'b1;
    tick(1);
    intr_i = 1'b0;
    wait_load("sim_ret_load", l0);
    chk("sim_ret_retf", {31'b0, retf_at_load}, 1);
    wait_load("sim_ent_load", l0 + 1);
    chk("sim_savef", n_save - s0, 1);
    chk("sim_gap_ok", {31'b0, (save_cyc - ret_cyc) >= 5}, 1);
    rd_delay = 0;
    do_return(8'h1E, 8'h66, "sim_rti");

    // Reset in the middle of a stalled push.
    wr_delay = 6;
    sp_i = 8'h50;
    pc_i = 8'h77;
    intr_i = 1'b1;
    tick(1);
    intr_i = 1'b0;
    k = 0;
    while (!(mem_bus.mem_req && mem_bus.mem_we) && k < 40) begin
      tick(1);
      k++;
    end
    chk("rstp_in_push", {31'b0, mem_bus.mem_req && mem_bus.mem_we}, 1);
    tick(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rstp");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wr_delay = 0;
    l0 = n_load;
    tick(30);
    chk("rstp_no_load", n_load - l0, 0);
    chk("rstp_still_idle", {29'b0, dbg_state}, {29'b0, IDLE});

    // Stack pointer wrap on the pop address.
    do_entry(8'h10, 8'h33, 8'hB0, "wrap", 9);
    poke(8'h00, 8'h44);
    do_return(8'hFF, 8'h44, "wrap_rti");

    tick(5);
    chk("never_both_flags", n_both, 0);
    chk("bus_stable",       n_stab, 0);
    chk("spdec_on_ready",   n_dec_bad, 0);
    chk("unexpected_events", n_unexp, 0);
    chk("mem_q_left",       exp_mem_q.size(), 0);
    chk("pc_q_left",        exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Interrupt entry/return sequencer for the 8-bit pipelined processor.
- Detects an external interrupt and waits for the pipeline to drain.
- Entry: pulses saveF to the condition-code register, pushes the PC to the stack and loads the PC from the interrupt vector.
- Return: on RTI, pops the PC and pulses returnF so the saved flags are restored.

Parameters:
- PIPE_DEPTH, 4, cycles to wait after stall for in-flight instructions to retire.
- VEC_ADDR, 8'h01, memory address holding the ISR start address.
- AW, 8, address/data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- intr_i  in  1  external interrupt request, level or pulse, synchronous to clk
- rti_i  in  1  RTI decoded in execute stage, one-cycle pulse
- pc_i  in  AW  PC of next instruction to resume
- sp_i  in  AW  current stack pointer
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  memory address
- mem_wdata  out  AW  write data
- mem_rdata  in  AW  read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the request this cycle
- stall  out  1  freeze fetch/decode
- flush  out  1  one-cycle flush of fetch/decode
- saveF  out  1  one-cycle pulse: CCR copies flags [3:0] to [7:4]
- returnF  out  1  one-cycle pulse: CCR restores [3:0] from [7:4]
- pc_load  out  1  one-cycle pulse: PC <= pc_load_val
- pc_load_val  out  AW  new PC value
- sp_dec  out  1  one-cycle pulse: SP <= SP-1
- sp_inc  out  1  one-cycle pulse: SP <= SP+1
- in_isr  out  1  handler active; interrupts masked

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pending=0, in_isr=0, drain counter=0, saved PC register=0. All outputs are 0, including mem_addr/mem_wdata/pc_load_val.
- pending latch:
  - Set on intr_i=1 when in_isr=0 or while in RET_*.
  - Cleared on entry to DRAIN.
  - A second request while pending=1 is absorbed (single-depth).
- IDLE:
  - If pending=1 and in_isr=0 -> DRAIN; assert stall and a one-cycle flush on the transition cycle.
  - Else if rti_i=1 and in_isr=1 -> RET_POP.
  - rti_i with in_isr=0 is ignored.
- DRAIN:
  - stall=1; counter counts 0..PIPE_DEPTH-1.
  - On the last count, capture pc_i into the saved PC register -> SAVE.
- SAVE: saveF=1 for exactly this one cycle; stall=1 -> PUSH.
- PUSH:
  - mem_req=1, mem_we=1, mem_addr=sp_i, mem_wdata=saved PC.
  - Request, address and data are held stable until mem_ready.
  - On the mem_ready cycle: sp_dec=1 -> VEC.
- VEC:
  - mem_req=1, mem_we=0, mem_addr=VEC_ADDR.
  - On mem_ready: latch mem_rdata into pc_load_val -> JUMP.
- JUMP: pc_load=1 for one cycle; in_isr<=1; stall deasserts next cycle -> IDLE.
- RET_POP:
  - stall=1; mem_req=1, mem_we=0, mem_addr=sp_i+1 (8-bit wrap, 8'hFF+1=8'h00).
  - On mem_ready: sp_inc=1, latch mem_rdata -> RET_RESTORE.
- RET_RESTORE: returnF=1, pc_load=1, pc_load_val=popped PC, in_isr<=0 -> IDLE.
- Interrupt arriving during RET_*: latched into pending and serviced from IDLE the cycle after RET_RESTORE.
  - Its saveF therefore follows returnF by at least PIPE_DEPTH+1 cycles, so saveF and returnF are never high together.
- Memory wait: mem_ready may take any number of cycles; all state and outputs hold meanwhile. mem_ready while mem_req=0 is ignored.
- Reset mid-sequence: immediate return to IDLE; the interrupt is dropped and partial memory requests are abandoned.
- Latency, zero-wait memory: intr_i to pc_load = 1 (pending) + 1 (IDLE) + PIPE_DEPTH + 1 + 1 + 1 = 9 cycles at PIPE_DEPTH=4. rti_i to pc_load = 2 cycles.

Decomposition:
- Package int_seq_pkg:
  - state enum typedef (IDLE, DRAIN, SAVE, PUSH, VEC, JUMP, RET_POP, RET_RESTORE);
  - default VEC_ADDR;
  - AW.
- Sub-module int_mem_if: holds req/we/addr/wdata stable until ready and returns a one-cycle done strobe plus latched rdata. It is used by PUSH, VEC and RET_POP.

Test Plan:
- Basic entry: sp_i=8'hFF, pc_i=8'h23, M[1]=8'h80, mem_ready tied 1, intr_i pulse.
  - Required: saveF pulse; write M[FF]=23; sp_dec pulse; pc_load_val=80 exactly 9 cycles after intr_i; in_isr=1.
- Return: from the entry state above, sp_i=8'hFE, rti_i pulse.
  - Required: read addr FF; sp_inc pulse; returnF and pc_load together with pc_load_val=23; in_isr=0.
- Memory wait: mem_ready delayed 3 cycles in PUSH.
  - Required: mem_addr/mem_wdata constant for all 4 cycles; sp_dec only on the ready cycle; total latency +3.
- Masking and simultaneous events:
  - intr_i during ISR: no new saveF.
  - intr_i during RET_POP: returnF first, then saveF no earlier than 5 cycles later; saveF&returnF never both 1.
- Reset mid-PUSH: rst_n low for 1 cycle while mem_req=1.
  - Required: all outputs 0 immediately; state IDLE; no pc_load afterwards without a new intr_i.
- Stack wrap: sp_i=8'hFF at RTI.
  - Required: pop address 8'h00.
